axi_lite_slave_regfile: RTL and testbench

- AXI4-Lite slave that terminates the five AXI-Lite channels driven by the team's AXI-Lite master and maps them onto a bank of NUM_REGS memory-mapped registers.
- Write address and write data are accepted independently and in either order. Each channel has a one-entry holding register.
- Byte strobes, out-of-range error responses, and a one-cycle write-event pulse are provided for downstream control logic.

---
 rtl/axi_lite_slave_regfile_if.sv | 37 +++
 rtl/axi_lite_slave_regfile.sv | 248 ++++++++++++++++++++++++
 tb/tb_axi_lite_slave_regfile.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle between the team's AXI-Lite master and the register-file slave.
interface axi_lite_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   axi_awaddr;
    logic                    axi_awvalid;
    logic                    axi_awready;
    logic [DATA_WIDTH-1:0]   axi_wdata;
    logic [DATA_WIDTH/8-1:0] axi_wstrb;
    logic                    axi_wvalid;
    logic                    axi_wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   axi_araddr;
    logic                    axi_arvalid;
    logic                    axi_arready;
    logic [DATA_WIDTH-1:0]   axi_rdata;
    logic [1:0]              axi_rresp;
    logic                    axi_rvalid;
    logic                    axi_rready;

    modport slave (
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, bready,
        input  axi_araddr, axi_arvalid, axi_rready,
        output axi_awready, axi_wready, bresp, bvalid,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );

    modport master (
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, bready,
        output axi_araddr, axi_arvalid, axi_rready,
        input  axi_awready, axi_wready, bresp, bvalid,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );
endinterface

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave mapping the five channels onto NUM_REGS registers.
// AW and W may arrive in either order; each has a one-entry holding register.
// All bus outputs and the write-event pulse are registered.
module axi_lite_slave_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                       aclk,
    input  logic                       arst,
    axi_lite_slave_regfile_if.slave    s_axi,
    output logic                       wr_evt,
    output logic [7:0]                 wr_idx
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    w_state_e               w_state_q, w_state_d;
    r_state_e               r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [BYTES-1:0]       wstrb_q, wstrb_d;
    logic                   awready_q, awready_d;
    logic                   wready_q, wready_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic                   wr_evt_q, wr_evt_d;
    logic [7:0]             wr_idx_q, wr_idx_d;
    logic                   arready_q, arready_d;
    logic                   rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];

    logic                   aw_hs_s, w_hs_s;
    logic                   commit_s;
    logic [ADDR_WIDTH-1:0]  c_addr_s;
    logic [DATA_WIDTH-1:0]  c_data_s;
    logic [BYTES-1:0]       c_strb_s;
    logic [ADDR_WIDTH-1:0]  c_idx_s;
    logic                   c_inrange_s;
    logic [ADDR_WIDTH-1:0]  rd_idx_s;
    logic                   rd_inrange_s;

    assign aw_hs_s = awready_q & s_axi.axi_awvalid;
    assign w_hs_s  = wready_q & s_axi.axi_wvalid;

    // Write channel FSM: capture AW/W in either order, build the commit, hold B until accepted.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_evt_d  = 1'b0;
        wr_idx_d  = wr_idx_q;
        commit_s  = 1'b0;
        c_addr_s  = awaddr_q;
        c_data_s  = wdata_q;
        c_strb_s  = wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    commit_s = 1'b1;
                    c_addr_s = s_axi.axi_awaddr;
                    c_data_s = s_axi.axi_wdata;
                    c_strb_s = s_axi.axi_wstrb;
                end else if (aw_hs_s) begin
                    awaddr_d  = s_axi.axi_awaddr;
                    w_state_d = W_HAVE_ADDR;
                end else if (w_hs_s) begin
                    wdata_d   = s_axi.axi_wdata;
                    wstrb_d   = s_axi.axi_wstrb;
                    w_state_d = W_HAVE_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs_s) begin
                    commit_s = 1'b1;
                    c_data_s = s_axi.axi_wdata;
                    c_strb_s = s_axi.axi_wstrb;
                end else begin
                    w_state_d = W_HAVE_ADDR;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs_s) begin
                    commit_s = 1'b1;
                    c_addr_s = s_axi.axi_awaddr;
                end else begin
                    w_state_d = W_HAVE_DATA;
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
        // Upper address bits stay in the index so any nonzero high bit is out of range.
        c_idx_s     = c_addr_s >> OFFS;
        c_inrange_s = (c_idx_s < NUM_REGS_A);
        if (commit_s) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = c_inrange_s ? RESP_OKAY : RESP_SLVERR;
            wr_evt_d  = c_inrange_s;
            wr_idx_d  = c_inrange_s ? 8'(c_idx_s) : wr_idx_q;
        end else begin
            wr_evt_d  = 1'b0;
        end
        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
    end

    // Register bank update: byte lanes with strobe set take the committed data.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (commit_s && c_inrange_s) begin
            for (int b = 0; b < BYTES; b++) begin
                regs_d[c_idx_s[IDX_W-1:0]][b*8 +: 8] = c_strb_s[b] ?
                    c_data_s[b*8 +: 8] : regs_q[c_idx_s[IDX_W-1:0]][b*8 +: 8];
            end
        end else begin
            regs_d[0] = regs_q[0];
        end
    end

    // Read channel FSM: sample the pre-write bank on the AR handshake, hold R until accepted.
    always_comb begin
        r_state_d    = r_state_q;
        arready_d    = arready_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        rd_idx_s     = s_axi.axi_araddr >> OFFS;
        rd_inrange_s = (rd_idx_s < NUM_REGS_A);
        case (r_state_q)
            R_IDLE: begin
                if (s_axi.axi_arvalid) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_inrange_s ? regs_q[rd_idx_s[IDX_W-1:0]] : {DATA_WIDTH{1'b0}};
                    rresp_d   = rd_inrange_s ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (s_axi.axi_rready) begin
                    r_state_d = R_IDLE;
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    // State, holding registers, register bank and registered outputs; reset abandons everything.
    always_ff @(posedge aclk) begin
        if (arst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awaddr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            wstrb_q   <= {BYTES{1'b0}};
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            wr_evt_q  <= 1'b0;
            wr_idx_q  <= 8'd0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DATA_WIDTH{1'b0}};
            rresp_q   <= 2'b00;
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wr_evt_q  <= wr_evt_d;
            wr_idx_q  <= wr_idx_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    assign s_axi.axi_awready = awready_q;
    assign s_axi.axi_wready  = wready_q;
    assign s_axi.bvalid      = bvalid_q;
    assign s_axi.bresp       = bresp_q;
    assign s_axi.axi_arready = arready_q;
    assign s_axi.axi_rvalid  = rvalid_q;
    assign s_axi.axi_rdata   = rdata_q;
    assign s_axi.axi_rresp   = rresp_q;
    assign wr_evt            = wr_evt_q;
    assign wr_idx            = wr_idx_q;
endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Directed self-checking bench for axi_lite_slave_regfile (NUM_REGS=16, 32-bit data).
module tb_axi_lite_slave_regfile;
    logic       aclk;
    logic       arst;
    logic       wr_evt;
    logic [7:0] wr_idx;
    int         n_checks;
    int         n_errors;

    axi_lite_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .aclk   (aclk),
        .arst   (arst),
        .s_axi  (bus),
        .wr_evt (wr_evt),
        .wr_idx (wr_idx)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // AW and W presented together, then B accepted.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input logic exp_evt, input logic [7:0] exp_idx);
        bus.axi_awaddr = addr; bus.axi_awvalid = 1'b1;
        bus.axi_wdata = data; bus.axi_wstrb = strb; bus.axi_wvalid = 1'b1;
        step();
        bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
        check({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
        check({tag, "_bresp"}, 32'(bus.bresp), 32'(exp_resp));
        check({tag, "_wr_evt"}, 32'(wr_evt), 32'(exp_evt));
        if (exp_evt) check({tag, "_wr_idx"}, 32'(wr_idx), 32'(exp_idx));
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check({tag, "_bvalid_clr"}, 32'(bus.bvalid), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bus.axi_araddr = addr; bus.axi_arvalid = 1'b1;
        step();
        bus.axi_arvalid = 1'b0;
        check({tag, "_rvalid"}, 32'(bus.axi_rvalid), 32'd1);
        check({tag, "_rdata"}, bus.axi_rdata, exp_data);
        check({tag, "_rresp"}, 32'(bus.axi_rresp), 32'(exp_resp));
        check({tag, "_arready"}, 32'(bus.axi_arready), 32'd0);
        bus.axi_rready = 1'b1;
        step();
        bus.axi_rready = 1'b0;
        check({tag, "_rvalid_clr"}, 32'(bus.axi_rvalid), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        arst = 1'b1;
        bus.axi_awaddr = 32'd0; bus.axi_awvalid = 1'b0;
        bus.axi_wdata = 32'd0; bus.axi_wstrb = 4'h0; bus.axi_wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.axi_araddr = 32'd0; bus.axi_arvalid = 1'b0; bus.axi_rready = 1'b0;
        step();
        step();
        arst = 1'b0;

        // Reset values
        check("rst_awready", 32'(bus.axi_awready), 32'd1);
        check("rst_wready",  32'(bus.axi_wready), 32'd1);
        check("rst_arready", 32'(bus.axi_arready), 32'd1);
        check("rst_bvalid",  32'(bus.bvalid), 32'd0);
        check("rst_rvalid",  32'(bus.axi_rvalid), 32'd0);
        check("rst_wr_evt",  32'(wr_evt), 32'd0);
        check("rst_bresp",   32'(bus.bresp), 32'd0);
        check("rst_rresp",   32'(bus.axi_rresp), 32'd0);
        check("rst_rdata",   bus.axi_rdata, 32'd0);
        check("rst_wr_idx",  32'(wr_idx), 32'd0);

        // Simultaneous AW/W to register 1, with ready drop in W_RESP
        bus.axi_awaddr = 32'h04; bus.axi_awvalid = 1'b1;
        bus.axi_wdata = 32'hDEADBEEF; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
        step();
        bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
        check("t1_wr_evt", 32'(wr_evt), 32'd1);
        check("t1_wr_idx", 32'(wr_idx), 32'd1);
        check("t1_bvalid", 32'(bus.bvalid), 32'd1);
        check("t1_bresp", 32'(bus.bresp), 32'd0);
        check("t1_awready", 32'(bus.axi_awready), 32'd0);
        check("t1_wready", 32'(bus.axi_wready), 32'd0);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("t1_bvalid_clr", 32'(bus.bvalid), 32'd0);
        check("t1_wr_evt_clr", 32'(wr_evt), 32'd0);
        check("t1_awready_back", 32'(bus.axi_awready), 32'd1);
        do_read("t1_rd", 32'h04, 32'hDEADBEEF, 2'b00);

        // W before AW with partial strobes on register 2
        do_write("t2_pre", 32'h08, 32'hAABBCCDD, 4'hF, 2'b00, 1'b1, 8'd2);
        bus.axi_wdata = 32'h11223344; bus.axi_wstrb = 4'h5; bus.axi_wvalid = 1'b1;
        step();
        bus.axi_wvalid = 1'b0;
        check("t2_wready_wait0", 32'(bus.axi_wready), 32'd0);
        check("t2_awready_wait0", 32'(bus.axi_awready), 32'd1);
        step();
        check("t2_wready_wait1", 32'(bus.axi_wready), 32'd0);
        step();
        check("t2_wready_wait2", 32'(bus.axi_wready), 32'd0);
        check("t2_bvalid_wait", 32'(bus.bvalid), 32'd0);
        bus.axi_awaddr = 32'h08; bus.axi_awvalid = 1'b1;
        step();
        bus.axi_awvalid = 1'b0;
        check("t2_wr_evt", 32'(wr_evt), 32'd1);
        check("t2_wr_idx", 32'(wr_idx), 32'd2);
        check("t2_bvalid", 32'(bus.bvalid), 32'd1);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        do_read("t2_rd", 32'h08, 32'hAA22CC44, 2'b00);

        // Out-of-range and boundary indices
        do_write("t3_oor", 32'h40, 32'h12345678, 4'hF, 2'b10, 1'b0, 8'd0);
        do_read("t3_oor_rd", 32'h40, 32'h0, 2'b10);
        do_read("t3_hibit_rd", 32'h80000004, 32'h0, 2'b10);
        do_write("t3_last", 32'h3C, 32'hCAFEF00D, 4'hF, 2'b00, 1'b1, 8'd15);
        do_read("t3_last_rd", 32'h3E, 32'hCAFEF00D, 2'b00);
        do_write("t3_strb0", 32'h3C, 32'hFFFFFFFF, 4'h0, 2'b00, 1'b1, 8'd15);
        do_read("t3_strb0_rd", 32'h3C, 32'hCAFEF00D, 2'b00);

        // AW before W, then B back-pressure with a second AW waiting
        bus.axi_awaddr = 32'h0C; bus.axi_awvalid = 1'b1;
        step();
        bus.axi_awvalid = 1'b0;
        check("t4_awready_held", 32'(bus.axi_awready), 32'd0);
        check("t4_wready_held", 32'(bus.axi_wready), 32'd1);
        bus.axi_wdata = 32'h9; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
        step();
        bus.axi_wvalid = 1'b0;
        check("t4_wr_evt", 32'(wr_evt), 32'd1);
        check("t4_wr_idx", 32'(wr_idx), 32'd3);
        bus.axi_awaddr = 32'h00; bus.axi_awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_bvalid_hold", 32'(bus.bvalid), 32'd1);
            check("t4_bresp_hold", 32'(bus.bresp), 32'd0);
            check("t4_awready_hold", 32'(bus.axi_awready), 32'd0);
            check("t4_wr_evt_hold", 32'(wr_evt), 32'd0);
        end
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("t4_bvalid_clr", 32'(bus.bvalid), 32'd0);
        check("t4_awready_idle", 32'(bus.axi_awready), 32'd1);
        step();
        bus.axi_awvalid = 1'b0;
        check("t4_aw2_taken", 32'(bus.axi_awready), 32'd0);
        bus.axi_wdata = 32'h77; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
        step();
        bus.axi_wvalid = 1'b0;
        check("t4_aw2_wr_idx", 32'(wr_idx), 32'd0);
        check("t4_aw2_wr_evt", 32'(wr_evt), 32'd1);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        do_read("t4_rd0", 32'h00, 32'h77, 2'b00);

        // Read sampled on the same edge as a write commit returns the old value
        bus.axi_awaddr = 32'h0C; bus.axi_awvalid = 1'b1;
        bus.axi_wdata = 32'h5; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
        bus.axi_araddr = 32'h0C; bus.axi_arvalid = 1'b1;
        step();
        bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0; bus.axi_arvalid = 1'b0;
        check("t5_wr_evt", 32'(wr_evt), 32'd1);
        check("t5_rvalid", 32'(bus.axi_rvalid), 32'd1);
        check("t5_rdata_old", bus.axi_rdata, 32'h9);
        bus.bready = 1'b1; bus.axi_rready = 1'b1;
        step();
        bus.bready = 1'b0; bus.axi_rready = 1'b0;
        do_read("t5_rd_new", 32'h0C, 32'h5, 2'b00);

        // Reset while in W_HAVE_ADDR and R_DATA
        bus.axi_awaddr = 32'h04; bus.axi_awvalid = 1'b1;
        bus.axi_araddr = 32'h04; bus.axi_arvalid = 1'b1;
        step();
        bus.axi_awvalid = 1'b0; bus.axi_arvalid = 1'b0;
        check("t6_pre_awready", 32'(bus.axi_awready), 32'd0);
        check("t6_pre_rvalid", 32'(bus.axi_rvalid), 32'd1);
        arst = 1'b1;
        step();
        arst = 1'b0;
        check("t6_bvalid", 32'(bus.bvalid), 32'd0);
        check("t6_rvalid", 32'(bus.axi_rvalid), 32'd0);
        check("t6_awready", 32'(bus.axi_awready), 32'd1);
        check("t6_wready", 32'(bus.axi_wready), 32'd1);
        check("t6_arready", 32'(bus.axi_arready), 32'd1);
        check("t6_wr_evt", 32'(wr_evt), 32'd0);
        bus.axi_wdata = 32'h0BAD0BAD; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1'b1;
        step();
        bus.axi_wvalid = 1'b0;
        check("t6_no_bvalid", 32'(bus.bvalid), 32'd0);
        check("t6_w_only_wready", 32'(bus.axi_wready), 32'd0);
        arst = 1'b1;
        step();
        arst = 1'b0;
        do_read("t6_rd1", 32'h04, 32'h0, 2'b00);
        do_read("t6_rd2", 32'h08, 32'h0, 2'b00);
        do_read("t6_rd15", 32'h3C, 32'h0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Overall time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
